fiberin_seq_monitor: RTL and testbench
======================================

FIBERIN_SEQ_MONITOR -- requirements
Module: fiberin_seq_monitor

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the sample width per channel.
REQ-002 The block SHALL have parameter NCH, default 4, the number of independent fiber channels.
REQ-003 The block SHALL have parameter CNT_W, default 48, the width of each sample and error counter.
REQ-004 The block SHALL have parameter LOCK_CNT, default 4, the consecutive good steps needed to declare lock.
REQ-005 The block SHALL have parameter LOSS_CNT, default 3, the consecutive bad steps needed to drop lock.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous assert, active-low.
REQ-008 The block SHALL have port valid, input, NCH bits, the per-channel sample strobe.
REQ-009 The block SHALL have port data_in, input, NCH*DATA_W bits; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 The block SHALL have port clear, input, 1 bit, a synchronous pulse that zeroes all live counters.
REQ-011 The block SHALL have port snap, input, 1 bit, a pulse that copies all live counters to shadow registers.
REQ-012 The block SHALL have port rd_sel, input, ceil(log2(NCH)) bits (minimum 1), the shadow readout channel select.
REQ-013 The block SHALL have port rd_sample_cnt, output, CNT_W bits, the selected shadow sample count.
REQ-014 The block SHALL have port rd_err_cnt, output, CNT_W bits, the selected shadow error count.
REQ-015 The block SHALL have port rd_status, output, 4 bits: {sat_flag, state[1:0], lock} of the selected channel.
REQ-016 The block SHALL have port lock, output, NCH bits; bit k is 1 while channel k is LOCKED.
REQ-017 The block SHALL have port err_pulse, output, NCH bits: a 1-cycle strobe per counted error.

Function
REQ-018 Each channel SHALL run an independent FSM with states UNLOCKED=0, LOCKING=1, LOCKED=2.
REQ-019 A step SHALL be good when data_in equals expected, where expected = previous sample + 1 modulo 2^DATA_W (all-ones followed by 0 is good).
REQ-020 Every valid sample SHALL load expected <= data_in + 1 (mod 2^DATA_W), whatever the step outcome, so a single glitch costs one error and is not counted as a cascade.
REQ-021 UNLOCKED, on a valid sample, SHALL load expected, set run=0 and go to LOCKING; no error is counted.
REQ-022 LOCKING, on a good step, SHALL increment run and go to LOCKED when run reaches LOCK_CNT, with miss=0.
REQ-023 LOCKING, on a bad step, SHALL set run=0, stay in LOCKING and count no error.
REQ-024 LOCKED, on a bad step, SHALL increment err_cnt and miss, and assert err_pulse on the next cycle.
REQ-025 LOCKED, when miss reaches LOSS_CNT, SHALL go to UNLOCKED (that bad step is still counted).
REQ-026 LOCKED, on a good step, SHALL clear miss.
REQ-027 sample_cnt SHALL increment on every valid sample in every state.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and set a per-channel sticky sat_flag.
REQ-029 sat_flag SHALL clear only on clear or reset.
REQ-030 A cycle without valid SHALL change no channel state or counter.
REQ-031 clear SHALL zero all live counters and sat_flags on the next edge without changing FSM state.
REQ-032 A valid sample coinciding with clear SHALL update the FSM but leave counters at 0.
REQ-033 snap SHALL load the shadow registers with the live values from before that edge's update.
REQ-034 When snap and clear coincide, the shadows SHALL receive the pre-clear values.
REQ-035 rd_sel SHALL be registered; rd_* outputs SHALL reflect the shadow of the channel selected one cycle earlier.
REQ-036 An rd_sel value >= NCH SHALL return all zeros.
REQ-037 The lock output SHALL be registered and follow the state register with no extra delay.

Reset
REQ-038 While rst_n=0, the block SHALL hold all FSMs in UNLOCKED, and all counters, shadows, expected, run, miss, sat_flags, lock, err_pulse and rd_* outputs at 0.
REQ-039 The first valid sample after rst_n deasserts SHALL be treated per REQ-021.

Verification
REQ-040 A bench SHALL check: ch0 ramp 0x0010,0x0011,... for 10 samples -> lock[0]=1 after the 5th sample; err_cnt=0; sample_cnt=10.
REQ-041 A bench SHALL check: a locked ch1 receiving ...,0x0100,0x0555,0x0556,... -> err_cnt=1; err_pulse[1] high for exactly 1 cycle; lock stays 1.
REQ-042 A bench SHALL check: a locked ch2 receiving 3 consecutive bad steps -> err_cnt=3; lock[2]=0 after the 3rd; the next sample is not counted as an error.
REQ-043 A bench SHALL check: ch3 crossing 0xFFFE,0xFFFF,0x0000,0x0001 -> no error.
REQ-044 A bench SHALL check: snap and clear together with ch0 sample_cnt=10 -> rd_sel=0 yields rd_sample_cnt=10 one cycle later; live count is 0.
REQ-045 A bench SHALL check: with CNT_W=4, 20 valid samples -> sample_cnt=15 and sat_flag=1; asserting rst_n=0 mid-stream immediately zeroes all outputs.

Source files
------------

// File: rtl/fiberin_seq_monitor.sv
// fiberin_seq_monitor
//   Sequence-integrity monitor for NCH fiber channels. On each valid sample,
//   a channel checks that the sample equals the previous sample + 1, modulo
//   2^DATA_W. The lock FSM, the saturating sample and error counters, and the
//   snapshot shadows are all per channel.
//
//   Ports
//     clk, rst_n      clock, async active-low reset
//     valid[NCH]      per-channel sample strobe
//     data_in         channel k at [k*DATA_W +: DATA_W]
//     clear           zero live counters and sat flags (FSM state untouched)
//     snap            copy live counters/status into shadows (pre-update values)
//     rd_sel          shadow readout select (registered); values >= NCH read 0
//     rd_sample_cnt   shadow sample count of the selected channel
//     rd_err_cnt      shadow error count of the selected channel
//     rd_status       {sat_flag, state[1:0], lock} shadow of the selected channel
//     lock[NCH]       channel is LOCKED
//     err_pulse[NCH]  one-cycle strobe per error seen while LOCKED

// Per-channel lane: lock FSM, expected-value tracker, counters, and shadows.
module fiberin_seq_chan #(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 48,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  input  logic              snap,
  output logic              lock,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  sh_sample,
  output logic [CNT_W-1:0]  sh_err,
  output logic [3:0]        sh_status
);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   exp_q;
  logic [RUN_W-1:0]    run_q, run_d, run_inc;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic [CNT_W-1:0]    scnt_q, ecnt_q;
  logic                sat_q, lock_q, errp_q;
  logic                good, err_hit;

  assign good     = (data == exp_q);
  assign run_inc  = run_q + RUN_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= UNLOCKED;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (valid) begin
      case (state_q)
        UNLOCKED: state_d = LOCKING;
        LOCKING:  if (good && run_inc == RUN_W'(LOCK_CNT)) state_d = LOCKED;
        LOCKED:   if (!good && miss_inc == MISS_W'(LOSS_CNT)) state_d = UNLOCKED;
        default:  state_d = UNLOCKED;
      endcase
    end
  end

  // Output / datapath control
  always_comb begin
    run_d   = run_q;
    miss_d  = miss_q;
    err_hit = 1'b0;
    if (valid) begin
      case (state_q)
        UNLOCKED: begin
          run_d  = '0;
          miss_d = '0;
        end
        LOCKING: begin
          miss_d = '0;
          run_d  = good ? run_inc : '0;
        end
        LOCKED: begin
          if (good) miss_d = '0;
          else begin
            err_hit = 1'b1;
            // miss restarts when the channel drops back to UNLOCKED
            miss_d  = (miss_inc == MISS_W'(LOSS_CNT)) ? '0 : miss_inc;
          end
        end
        default: begin
          run_d  = '0;
          miss_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      scnt_q    <= '0;
      ecnt_q    <= '0;
      sat_q     <= 1'b0;
      lock_q    <= 1'b0;
      errp_q    <= 1'b0;
      sh_sample <= '0;
      sh_err    <= '0;
      sh_status <= '0;
    end else begin
      run_q  <= run_d;
      miss_q <= miss_d;
      lock_q <= (state_d == LOCKED);
      // The pulse marks the detected error even if clear keeps the counter at 0.
      errp_q <= err_hit;
      // Re-arm on every sample, so one glitch costs one error.
      if (valid) exp_q <= data + DATA_W'(1);

      if (clear) begin
        scnt_q <= '0;
        ecnt_q <= '0;
        sat_q  <= 1'b0;
      end else begin
        if (valid) begin
          if (&scnt_q) sat_q  <= 1'b1;
          else         scnt_q <= scnt_q + CNT_W'(1);
        end
        if (err_hit) begin
          if (&ecnt_q) sat_q  <= 1'b1;
          else         ecnt_q <= ecnt_q + CNT_W'(1);
        end
      end

      // Shadows take the pre-edge live values, so snap+clear keeps the old counts.
      if (snap) begin
        sh_sample <= scnt_q;
        sh_err    <= ecnt_q;
        sh_status <= {sat_q, state_q, lock_q};
      end
    end
  end

  assign lock      = lock_q;
  assign err_pulse = errp_q;
endmodule

module fiberin_seq_monitor #(
  parameter  int DATA_W   = 16,
  parameter  int NCH      = 4,
  parameter  int CNT_W    = 48,
  parameter  int LOCK_CNT = 4,
  parameter  int LOSS_CNT = 3,
  localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        valid,
  input  logic [NCH*DATA_W-1:0] data_in,
  input  logic                  clear,
  input  logic                  snap,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_W-1:0]      rd_sample_cnt,
  output logic [CNT_W-1:0]      rd_err_cnt,
  output logic [3:0]            rd_status,
  output logic [NCH-1:0]        lock,
  output logic [NCH-1:0]        err_pulse
);
  logic [NCH-1:0][CNT_W-1:0] sh_sample, sh_err;
  logic [NCH-1:0][3:0]       sh_status;
  logic [SEL_W-1:0]          rd_sel_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    fiberin_seq_chan #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (valid[g]),
      .data      (data_in[g*DATA_W +: DATA_W]),
      .clear     (clear),
      .snap      (snap),
      .lock      (lock[g]),
      .err_pulse (err_pulse[g]),
      .sh_sample (sh_sample[g]),
      .sh_err    (sh_err[g]),
      .sh_status (sh_status[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sel_q <= '0;
    else        rd_sel_q <= rd_sel;
  end

  // Any unmatched select (>= NCH) falls through to zero.
  always_comb begin
    rd_sample_cnt = '0;
    rd_err_cnt    = '0;
    rd_status     = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_sel_q == SEL_W'(k)) begin
        rd_sample_cnt = sh_sample[k];
        rd_err_cnt    = sh_err[k];
        rd_status     = sh_status[k];
      end
    end
  end
endmodule

// File: tb/tb_fiberin_seq_monitor.sv
module tb_fiberin_seq_monitor;
  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT1: default geometry
  logic        rst_n;
  logic [3:0]  valid;
  logic [63:0] data_in;
  logic        clear, snap;
  logic [1:0]  rd_sel;
  logic [47:0] rd_sample_cnt, rd_err_cnt;
  logic [3:0]  rd_status, lock, err_pulse;

  // DUT2: 3 channels, 4-bit counters (saturation + out-of-range select)
  logic        rst2_n;
  logic [2:0]  valid2;
  logic [47:0] data2;
  logic        clear2, snap2;
  logic [1:0]  rd_sel2;
  logic [3:0]  rd_sample2, rd_err2, rd_status2;
  logic [2:0]  lock2, err_pulse2;

  fiberin_seq_monitor #(.DATA_W(16), .NCH(4), .CNT_W(48), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .data_in(data_in), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_sample_cnt(rd_sample_cnt), .rd_err_cnt(rd_err_cnt),
    .rd_status(rd_status), .lock(lock), .err_pulse(err_pulse));

  fiberin_seq_monitor #(.DATA_W(16), .NCH(3), .CNT_W(4), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut2 (
    .clk(clk), .rst_n(rst2_n), .valid(valid2), .data_in(data2), .clear(clear2), .snap(snap2),
    .rd_sel(rd_sel2), .rd_sample_cnt(rd_sample2), .rd_err_cnt(rd_err2),
    .rd_status(rd_status2), .lock(lock2), .err_pulse(err_pulse2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model of DUT1. Mode: 0 hunting, 1 building a run, 2 locked.
  int          mmode[4], mrun[4], mmiss[4];
  logic [15:0] mprev[4];
  longint      msamp[4], merr[4], shs[4], she[4];
  bit          msat[4], mpulse[4];
  logic [3:0]  shst[4];
  int          msel;
  localparam longint CMAX = (64'd1 << 48) - 1;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mmode[k] = 0; mrun[k] = 0; mmiss[k] = 0; mprev[k] = '0;
      msamp[k] = 0; merr[k] = 0; shs[k] = 0; she[k] = 0;
      msat[k] = 0; mpulse[k] = 0; shst[k] = '0;
    end
    msel = 0;
  endtask

  task automatic model_step();
    logic [15:0] d;
    bit good;
    if (snap)
      for (int k = 0; k < 4; k++) begin
        shs[k] = msamp[k];
        she[k] = merr[k];
        shst[k] = {msat[k], 2'(mmode[k]), mmode[k] == 2};
      end
    msel = int'(rd_sel);
    for (int k = 0; k < 4; k++) begin
      mpulse[k] = 0;
      if (valid[k]) begin
        d = data_in[k*16 +: 16];
        good = (d == 16'(mprev[k] + 16'd1));
        mprev[k] = d;
        if (mmode[k] == 0) begin
          mmode[k] = 1; mrun[k] = 0;
        end else if (mmode[k] == 1) begin
          if (good) begin
            mrun[k]++;
            if (mrun[k] == LOCK) begin mmode[k] = 2; mmiss[k] = 0; end
          end else mrun[k] = 0;
        end else begin
          if (good) mmiss[k] = 0;
          else begin
            mpulse[k] = 1;
            if (merr[k] == CMAX) msat[k] = 1; else merr[k]++;
            mmiss[k]++;
            if (mmiss[k] == LOSS) begin mmode[k] = 0; mmiss[k] = 0; end
          end
        end
        if (msamp[k] == CMAX) msat[k] = 1; else msamp[k]++;
      end
      if (clear) begin msamp[k] = 0; merr[k] = 0; msat[k] = 0; end
    end
  endtask

  // Every-cycle comparison of DUT1 against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("lock[%0d]", k), 64'(lock[k]), 64'(mmode[k] == 2));
        chk($sformatf("err_pulse[%0d]", k), 64'(err_pulse[k]), 64'(mpulse[k]));
      end
      chk("rd_sample_cnt", 64'(rd_sample_cnt), 64'(shs[msel]));
      chk("rd_err_cnt", 64'(rd_err_cnt), 64'(she[msel]));
      chk("rd_status", 64'(rd_status), 64'(shst[msel]));
    end
  end

  task automatic put(input int ch, input logic [15:0] d);
    valid[ch] = 1'b1;
    data_in[ch*16 +: 16] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    valid = '0; snap = 1'b0; clear = 1'b0;
    valid2 = '0; snap2 = 1'b0; clear2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    valid = '0; data_in = '0; clear = 1'b0; snap = 1'b0; rd_sel = '0;
    valid2 = '0; data2 = '0; clear2 = 1'b0; snap2 = 1'b0; rd_sel2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_lock", 64'(lock), 64'h0);
    chk("reset_rd_sample", 64'(rd_sample_cnt), 64'h0);
    chk("reset_rd_status", 64'(rd_status), 64'h0);
    rst_n = 1'b1;

    // ch0 ramp: lock after the 5th sample
    for (int i = 0; i < 10; i++) begin
      put(0, 16'h0010 + 16'(i));
      tick();
      if (i == 3) chk("ch0_lock_after4", 64'(lock[0]), 64'h0);
      if (i == 4) chk("ch0_lock_after5", 64'(lock[0]), 64'h1);
    end
    // snap + clear together: shadow keeps 10, live goes to 0
    snap = 1'b1; clear = 1'b1; rd_sel = 2'd0;
    tick();
    chk("ch0_shadow_samples", 64'(rd_sample_cnt), 64'd10);
    chk("ch0_shadow_errs", 64'(rd_err_cnt), 64'd0);
    chk("ch0_shadow_status", 64'(rd_status), 64'b0101);
    snap = 1'b1;
    tick();
    chk("ch0_live_cleared", 64'(rd_sample_cnt), 64'd0);
    chk("ch0_lock_kept", 64'(lock[0]), 64'h1);

    // ch1 single glitch
    for (int i = 0; i < 5; i++) begin put(1, 16'h00FC + 16'(i)); tick(); end
    chk("ch1_locked", 64'(lock[1]), 64'h1);
    put(1, 16'h0555); tick();
    chk("ch1_pulse_on", 64'(err_pulse[1]), 64'h1);
    put(1, 16'h0556); tick();
    chk("ch1_pulse_off", 64'(err_pulse[1]), 64'h0);
    chk("ch1_still_locked", 64'(lock[1]), 64'h1);
    put(1, 16'h0557); tick();
    snap = 1'b1; rd_sel = 2'd1; tick();
    chk("ch1_errs", 64'(rd_err_cnt), 64'd1);
    chk("ch1_samples", 64'(rd_sample_cnt), 64'd8);

    // ch2 loses lock after 3 bad steps
    for (int i = 0; i < 5; i++) begin put(2, 16'h0200 + 16'(i)); tick(); end
    put(2, 16'h0300); tick();
    put(2, 16'h0400); tick();
    chk("ch2_lock_after2bad", 64'(lock[2]), 64'h1);
    put(2, 16'h0500); tick();
    chk("ch2_lock_after3bad", 64'(lock[2]), 64'h0);
    tick();  // idle cycle
    put(2, 16'h0501); tick();
    chk("ch2_no_pulse_after_loss", 64'(err_pulse[2]), 64'h0);
    snap = 1'b1; rd_sel = 2'd2; tick();
    chk("ch2_errs", 64'(rd_err_cnt), 64'd3);
    chk("ch2_samples", 64'(rd_sample_cnt), 64'd9);
    chk("ch2_status", 64'(rd_status), 64'b0010);

    // ch3 wrap with idle gaps, ch0 running alongside
    for (int i = 0; i < 7; i++) begin
      put(3, 16'hFFFB + 16'(i));
      put(0, 16'h001A + 16'(i));
      tick();
      tick();
    end
    chk("ch3_locked", 64'(lock[3]), 64'h1);
    snap = 1'b1; rd_sel = 2'd3; tick();
    chk("ch3_errs", 64'(rd_err_cnt), 64'd0);
    chk("ch3_samples", 64'(rd_sample_cnt), 64'd7);
    rd_sel = 2'd0; tick();
    chk("ch0_samples_after_clear", 64'(rd_sample_cnt), 64'd7);

    // DUT2: saturation, out-of-range select, async reset mid-stream
    rst2_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid2 = 3'b001; data2[15:0] = 16'(i);
      tick();
    end
    chk("d2_lock", 64'(lock2[0]), 64'h1);
    snap2 = 1'b1; rd_sel2 = 2'd0; tick();
    chk("d2_sat_samples", 64'(rd_sample2), 64'd15);
    chk("d2_errs", 64'(rd_err2), 64'd0);
    chk("d2_status", 64'(rd_status2), 64'b1101);
    rd_sel2 = 2'd3; tick();
    chk("d2_sel_oob_samples", 64'(rd_sample2), 64'd0);
    chk("d2_sel_oob_status", 64'(rd_status2), 64'd0);
    rd_sel2 = 2'd0; tick();
    chk("d2_sel_back", 64'(rd_sample2), 64'd15);
    valid2 = 3'b001; data2[15:0] = 16'd20;
    @(posedge clk);
    model_step();
    #3;
    rst2_n = 1'b0;
    #1;
    chk("d2_rst_lock", 64'(lock2), 64'h0);
    chk("d2_rst_pulse", 64'(err_pulse2), 64'h0);
    chk("d2_rst_rd_sample", 64'(rd_sample2), 64'h0);
    chk("d2_rst_rd_err", 64'(rd_err2), 64'h0);
    chk("d2_rst_rd_status", 64'(rd_status2), 64'h0);
    tick();
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
